reg_ctrl_unit: RTL

Control unit that drives the 4-bit command ports (HOLD/LOAD/SHIFTR/SHIFTL/CLEAR) of datapath registers X, Y and Z, plus the ALU function select. It accepts one operation request at a time through a start/busy/done handshake and expands it into a timed sequence of register commands. Datapath: X loads external data, Y loads ALU(X, Z), Z loads Y. The registers act on the falling edge; this unit updates on the rising edge, so commands are stable at every falling edge.

---
 rtl/reg_ctrl_pkg.sv | 33 +++
 rtl/reg_ctrl_if.sv | 24 ++
 rtl/reg_ctrl_shift_cnt.sv | 38 +++
 rtl/reg_ctrl_unit.sv | 139 +++++++++++++
 4 files changed

// File: rtl/reg_ctrl_pkg.sv
// Shared constants for the register control unit: command codes used by
// registers X/Y/Z, operation codes, ALU selects and the FSM state encoding.
package reg_ctrl_pkg;

    localparam logic [3:0] CMD_HOLD   = 4'b0000;
    localparam logic [3:0] CMD_LOAD   = 4'b0001;
    localparam logic [3:0] CMD_SHIFTR = 4'b0010;
    localparam logic [3:0] CMD_SHIFTL = 4'b0011;
    localparam logic [3:0] CMD_CLEAR  = 4'b0100;

    localparam logic [2:0] OP_NOP       = 3'b000;
    localparam logic [2:0] OP_LOAD_X    = 3'b001;
    localparam logic [2:0] OP_ADD       = 3'b010;
    localparam logic [2:0] OP_SUB       = 3'b011;
    localparam logic [2:0] OP_SHR_Z     = 3'b100;
    localparam logic [2:0] OP_SHL_Z     = 3'b101;
    localparam logic [2:0] OP_CLEAR_ALL = 3'b110;
    localparam logic [2:0] OP_RSVD      = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EXEC_X   = 3'd1,
        ST_EXEC_ALU = 3'd2,
        ST_EXEC_Z   = 3'd3,
        ST_SHIFT    = 3'd4,
        ST_CLEAR    = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

endpackage

// File: rtl/reg_ctrl_if.sv
// Request/response and register-command bundle between a requester and the
// register control unit.
interface reg_ctrl_if;
    logic       start_i;
    logic [2:0] op_i;
    logic [1:0] amt_i;
    logic       busy_o;
    logic       done_o;
    logic       err_o;
    logic [3:0] tx_o;
    logic [3:0] ty_o;
    logic [3:0] tz_o;
    logic [1:0] ula_sel_o;

    modport master (
        output start_i, op_i, amt_i,
        input  busy_o, done_o, err_o, tx_o, ty_o, tz_o, ula_sel_o
    );

    modport slave (
        input  start_i, op_i, amt_i,
        output busy_o, done_o, err_o, tx_o, ty_o, tz_o, ula_sel_o
    );
endinterface

// File: rtl/reg_ctrl_shift_cnt.sv
// 2-bit shift down-counter: loads the remaining shift count, decrements per
// shift cycle and flags when it has reached zero.
module reg_ctrl_shift_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [1:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    // Next count: load wins over decrement
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - 2'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 2'd0);

endmodule

// File: rtl/reg_ctrl_unit.sv
// Register control unit: expands one accepted operation into a timed sequence
// of X/Y/Z register commands; all outputs are registered from the next state.
module reg_ctrl_unit
    import reg_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    reg_ctrl_if.slave    bus
);

    state_e     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [3:0] tx_q, tx_d, ty_q, ty_d, tz_q, tz_d;
    logic [1:0] ula_q, ula_d;
    logic       busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic       cnt_load_s, cnt_dec_s, cnt_zero_s;

    reg_ctrl_shift_cnt u_shift_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load_s),
        .load_val_i (bus.amt_i),
        .dec_i      (cnt_dec_s),
        .zero_o     (cnt_zero_s)
    );

    // Next state plus the outputs of the cycle that follows the edge
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        tx_d       = CMD_HOLD;
        ty_d       = CMD_HOLD;
        tz_d       = CMD_HOLD;
        ula_d      = ula_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        cnt_load_s = 1'b0;
        cnt_dec_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    op_d = bus.op_i;
                    case (bus.op_i)
                        OP_LOAD_X: begin
                            state_d = ST_EXEC_X;
                            tx_d    = CMD_LOAD;
                        end
                        OP_ADD, OP_SUB: begin
                            state_d = ST_EXEC_ALU;
                            ula_d   = (bus.op_i == OP_SUB) ? ALU_SUB : ALU_ADD;
                            ty_d    = CMD_LOAD;
                        end
                        OP_SHR_Z, OP_SHL_Z: begin
                            state_d    = ST_SHIFT;
                            cnt_load_s = 1'b1;
                            tz_d       = (bus.op_i == OP_SHL_Z) ? CMD_SHIFTL : CMD_SHIFTR;
                        end
                        OP_CLEAR_ALL: begin
                            state_d = ST_CLEAR;
                            tx_d    = CMD_CLEAR;
                            ty_d    = CMD_CLEAR;
                            tz_d    = CMD_CLEAR;
                        end
                        OP_RSVD: begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            err_d   = 1'b1;
                        end
                        default: begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC_ALU: begin
                state_d = ST_EXEC_Z;
                tz_d    = CMD_LOAD;
            end
            // Counter holds the shifts still owed after the current one
            ST_SHIFT: begin
                if (cnt_zero_s) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_dec_s = 1'b1;
                    tz_d      = (op_q == OP_SHL_Z) ? CMD_SHIFTL : CMD_SHIFTR;
                end
            end
            ST_EXEC_X, ST_EXEC_Z, ST_CLEAR: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            tx_q    <= CMD_HOLD;
            ty_q    <= CMD_HOLD;
            tz_q    <= CMD_HOLD;
            ula_q   <= ALU_ADD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            tz_q    <= tz_d;
            ula_q   <= ula_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.tx_o      = tx_q;
    assign bus.ty_o      = ty_q;
    assign bus.tz_o      = tz_q;
    assign bus.ula_sel_o = ula_q;
    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.err_o     = err_q;

endmodule
